// File: rtl/alu_pkg.sv
// Shared ALU control encodings and a legality helper used by the arbiter top
// and the ALU datapath.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    function automatic logic is_legal_aluc(input logic [3:0] aluc);
        return (aluc == ALU_AND) || (aluc == ALU_OR)  || (aluc == ALU_ADD) ||
               (aluc == ALU_SUB) || (aluc == ALU_SLT) || (aluc == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU; undefined control codes produce zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (aluc)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {31'd0, (a < b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping upward; grant is suppressed when en is low.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    int j;

    // Walk the search order backwards so the last hit is the first in priority.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            if (req[j]) begin
                grant_idx = IDW'(j);
                any       = 1'b1;
            end
        end
        grant = '0;
        if (en && any) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One shared ALU behind a round-robin arbiter, with a single-entry result
// register that refills on the same edge it is consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    input  logic [N_REQ*4-1:0]  req_aluc,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_result,
    output logic                rsp_zero,
    output logic                rsp_illegal
);

    logic           acc_en;
    logic           any;
    logic           handshake;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_idx;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic [3:0]     sel_aluc;
    logic [31:0]    alu_result;

    assign acc_en    = !rsp_valid || rsp_ready;
    assign handshake = any && acc_en;

    rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (acc_en),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign sel_a    = req_a[{grant_idx, 5'd0} +: 32];
    assign sel_b    = req_b[{grant_idx, 5'd0} +: 32];
    assign sel_aluc = req_aluc[{grant_idx, 2'd0} +: 4];

    alu_core u_alu (
        .a      (sel_a),
        .b      (sel_b),
        .aluc   (sel_aluc),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_id      <= '0;
            rsp_illegal <= 1'b0;
            ptr         <= '0;
        end else if (handshake) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= alu_result;
            rsp_zero    <= (alu_result == '0);
            rsp_id      <= grant_idx;
            rsp_illegal <= !is_legal_aluc(sel_aluc);
            ptr         <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed corner cases with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N*4-1:0]  req_aluc = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_result;
    logic           rsp_zero;
    logic           rsp_illegal;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic        m_valid, m_zero, m_illegal;
    logic [31:0] m_result;
    int          m_id, m_ptr;

    alu_share_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_aluc(req_aluc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] c, output logic ill);
        ill = 1'b0;
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1100: return ~(a | b);
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            default: begin ill = 1'b1; return 32'd0; end
        endcase
    endfunction

    function automatic int model_grant();
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (m_ptr + off) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_illegal = 0; m_result = 0; m_id = 0; m_ptr = 0;
    endtask

    // Called at posedge+1 with inputs set: check late in the cycle, advance model, cross the edge.
    task automatic cycle();
        int g;
        logic acc, ill;
        logic [N-1:0] exp_ready;
        #3;
        g = model_grant();
        acc = !m_valid || rsp_ready;
        exp_ready = '0;
        if (g >= 0 && acc) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_result", rsp_result, m_result);
            chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
            chk("rsp_illegal", 32'(rsp_illegal), 32'(m_illegal));
        end
        if (g >= 0 && acc) begin
            m_result  = alu_model(req_a[32*g +: 32], req_b[32*g +: 32], req_aluc[4*g +: 4], ill);
            m_illegal = ill;
            m_zero    = (m_result == 0);
            m_id      = g;
            m_valid   = 1;
            m_ptr     = (g + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_aluc[4*i +: 4] = c;
    endtask

    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        set_op(i, a, b, c);
        req_valid = '0;
        req_valid[i] = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
    endtask

    task automatic pin(input string name, input int id, input logic [31:0] res,
                       input logic zero, input logic ill);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_id"}, 32'(rsp_id), 32'(id));
        chk({name, "_result"}, rsp_result, res);
        chk({name, "_zero"}, 32'(rsp_zero), 32'(zero));
        chk({name, "_illegal"}, 32'(rsp_illegal), 32'(ill));
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0] pool [6];
        pool = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT};
        model_reset();

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        single(0, 32'd5, 32'd7, ALU_ADD);
        pin("add", 0, 32'd12, 1'b0, 1'b0);

        single(1, 32'd3, 32'd3, ALU_SUB);
        pin("sub_eq", 1, 32'd0, 1'b1, 1'b0);
        single(1, 32'd0, 32'd1, ALU_SUB);
        pin("sub_wrap", 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single(1, 32'd1, 32'hFFFF_FFFF, ALU_SLT);
        pin("slt", 1, 32'd1, 1'b0, 1'b0);
        single(1, 32'd0, 32'd0, ALU_NOR);
        pin("nor", 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single(1, 32'd9, 32'd4, 4'b1111);
        pin("illegal", 1, 32'd0, 1'b1, 1'b1);

        // Bring the pointer to 0 before the fairness run.
        single(3, 32'd1, 32'd1, ALU_ADD);
        chk("model_ptr_wrap", 32'(m_ptr), 32'd0);
        for (int i = 0; i < N; i++) set_op(i, 32'(i * 10), 32'd1, ALU_ADD);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_id", 32'(rsp_id), 32'(k % N));
            chk("fair_result", rsp_result, 32'((k % N) * 10 + 1));
        end

        // Backpressure with requester 2 waiting.
        req_valid = 4'b0100;
        set_op(2, 32'd100, 32'd23, ALU_SUB);
        rsp_ready = 1'b0;
        held = rsp_result;
        for (int k = 0; k < 3; k++) cycle();
        chk("stall_result", rsp_result, held);
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        pin("release", 2, 32'd77, 1'b0, 1'b0);

        single(3, 32'd0, 32'd0, ALU_OR);
        req_valid = 4'b1010;
        set_op(1, 32'hF0, 32'h0F, ALU_OR);
        set_op(3, 32'hF0, 32'h3C, ALU_AND);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("skip_id", 32'(rsp_id), (k % 2 == 0) ? 32'd1 : 32'd3);
            chk("skip_ptr", 32'(m_ptr), (k % 2 == 0) ? 32'd2 : 32'd0);
        end
        chk("skip_last_result", rsp_result, 32'h30);
        req_valid = '0;

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                logic [31:0] a, b;
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                set_op(i, a, b, ($urandom_range(0, 7) == 0) ? 4'($urandom) : pool[$urandom_range(0, 5)]);
            end
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        // Reset while a result is stalled.
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        single(0, 32'd2, 32'd2, ALU_ADD);
        rsp_ready = 1'b0;
        cycle();
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_result", rsp_result, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b0110;
        set_op(1, 32'd8, 32'd8, ALU_SUB);
        rsp_ready = 1'b1;
        cycle();
        pin("post_rst", 1, 32'd0, 1'b1, 1'b0);
        req_valid = '0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
